// File: rtl/conv2d_relu_engine_pkg.sv
// Shared types and helpers for the conv2d_relu_engine slice.
// Optional feature macro: CONV2D_MAXPOOL2_EN (2x2 max pooling after ReLU).
package conv2d_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CONV,
    WRITE,
    DONE
  } state_t;

  // Address width for a memory of n words, never below 1 bit.
  function automatic int unsigned aw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Valid-convolution output side; clamped so a bad KER_DIM still elaborates to the error check.
  function automatic int unsigned out_dim(input int unsigned img, input int unsigned ker);
    return (ker > img) ? 1 : img - ker + 1;
  endfunction

  // Number of dom words written per run.
  function automatic int unsigned dom_words(input int unsigned img, input int unsigned ker,
                                            input int unsigned nk);
    int unsigned od;
    od = out_dim(img, ker);
`ifdef CONV2D_MAXPOOL2_EN
    return nk * (od / 2) * (od / 2);
`else
    return nk * od * od;
`endif
  endfunction

  // Arithmetic shift, clamp negatives to zero and positives to the signed DATA_W maximum.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] acc, input int unsigned frac,
                                           input int unsigned dw);
    logic signed [63:0] r;
    logic signed [63:0] maxv;
    r    = acc >>> frac;
    maxv = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (r < 64'sd0)      return '0;
    else if (r > maxv)   return maxv;
    else                 return r;
  endfunction

endpackage

// File: rtl/conv2d_relu_engine_wbuf.sv
// Kernel weight register file: KK entries, synchronous indexed write, combinational tap read.
module kernel_weight_buffer
  import conv2d_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned KK     = 9,
  localparam int unsigned IW    = aw(KK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [IW-1:0] LAST = IW'(KK - 1);

  logic [DATA_W-1:0] regs [KK];

  // Weight storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < KK; i++) regs[i] <= '0;
    end else if (wr_en && (wr_idx <= LAST)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Tap read; out-of-range indices return zero.
  always_comb begin
    rd_data = '0;
    if (rd_idx <= LAST) rd_data = regs[rd_idx];
  end

endmodule

// File: rtl/conv2d_relu_engine.sv
// Parametrised 2-D valid convolution with signed MAC, ReLU and saturating truncation.
// Optional feature macro: CONV2D_MAXPOOL2_EN (2x2 max pooling, one dom write per block).
module conv2d_relu_engine
  import conv2d_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned IMG_DIM   = 16,
  parameter int unsigned KER_DIM   = 3,
  parameter int unsigned NUM_KER   = 8,
  parameter int unsigned ACC_W     = 2 * DATA_W + $clog2(KER_DIM * KER_DIM),
  localparam int unsigned BA = aw(NUM_KER * KER_DIM * KER_DIM),
  localparam int unsigned IA = aw(IMG_DIM * IMG_DIM),
  localparam int unsigned OA = aw(dom_words(IMG_DIM, KER_DIM, NUM_KER))
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xxx__dut__go,
  output logic              dut__xxx__finish,
  output logic [BA-1:0]     dut__bvm__address,
  output logic              dut__bvm__enable,
  output logic              dut__bvm__write,
  input  logic [DATA_W-1:0] bvm__dut__data,
  output logic [IA-1:0]     dut__dim__address,
  output logic              dut__dim__enable,
  output logic              dut__dim__write,
  input  logic [DATA_W-1:0] dim__dut__data,
  output logic [OA-1:0]     dut__dom__address,
  output logic [DATA_W-1:0] dut__dom__data,
  output logic              dut__dom__enable,
  output logic              dut__dom__write
);

  localparam int unsigned KK      = KER_DIM * KER_DIM;
  localparam int unsigned OUT_DIM = out_dim(IMG_DIM, KER_DIM);
  localparam int unsigned PW      = 2 * DATA_W;
  localparam int unsigned TW      = aw(KK + 1);
  localparam int unsigned KRW     = aw(KER_DIM);
  localparam int unsigned CW      = aw(OUT_DIM);
  localparam int unsigned KW      = aw(NUM_KER);
  localparam int unsigned IW      = aw(KK);

  localparam logic [TW-1:0]  TAP_END  = TW'(KK);
  localparam logic [KRW-1:0] KER_LAST = KRW'(KER_DIM - 1);
  localparam logic [CW-1:0]  OUT_LAST = CW'(OUT_DIM - 1);
  localparam logic [KW-1:0]  KRN_LAST = KW'(NUM_KER - 1);

  if (KER_DIM > IMG_DIM) begin : g_chk_ker
    $error("conv2d_relu_engine: KER_DIM must not exceed IMG_DIM");
  end
  if (ACC_W > 64) begin : g_chk_acc
    $error("conv2d_relu_engine: ACC_W above 64 bits is not supported");
  end
`ifdef CONV2D_MAXPOOL2_EN
  if ((OUT_DIM % 2) != 0) begin : g_chk_pool
    $error("conv2d_relu_engine: OUT_DIM must be even for 2x2 pooling");
  end
`endif

  state_t                   state, state_nx;
  logic [TW-1:0]            tap;
  logic [KRW-1:0]           tr, tc;
  logic [CW-1:0]            row, col;
  logic [KW-1:0]            kern;
  logic [OA-1:0]            out_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PW-1:0]     prod;
  logic [DATA_W-1:0]        w_rd, result, wr_val;
  logic                     wr_now, col_end, row_end, last_pix, tap_issue;

  assign tap_issue = (tap != TAP_END);
  assign col_end   = (col == OUT_LAST);
  assign row_end   = (row == OUT_LAST);
  assign last_pix  = col_end && row_end;
  assign prod      = PW'($signed(dim__dut__data)) * PW'($signed(w_rd));
  assign result    = DATA_W'(relu_sat(64'(acc), FRAC_BITS, DATA_W));

`ifdef CONV2D_MAXPOOL2_EN
  logic [1:0]        sub;
  logic [DATA_W-1:0] pool_max;
  // Pool value is the running block max; results are non-negative after ReLU.
  assign wr_val = ((sub == 2'd0) || (result > pool_max)) ? result : pool_max;
  assign wr_now = (sub == 2'd3);
`else
  assign wr_val = result;
  assign wr_now = 1'b1;
`endif

  kernel_weight_buffer #(.DATA_W(DATA_W), .KK(KK)) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   ((state == LOAD_W) && (tap != '0)),
    .wr_idx  (IW'(tap - 1'b1)),
    .wr_data (bvm__dut__data),
    .rd_idx  ((tap != '0) ? IW'(tap - 1'b1) : '0),
    .rd_data (w_rd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (xxx__dut__go) state_nx = LOAD_W;
      LOAD_W:  if (!tap_issue) state_nx = CONV;
      CONV:    if (!tap_issue) state_nx = WRITE;
      WRITE: begin
        if (!last_pix)              state_nx = CONV;
        else if (kern != KRN_LAST)  state_nx = LOAD_W;
        else                        state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes and addresses, zero whenever the matching strobe is low.
  always_comb begin
    dut__xxx__finish  = (state == IDLE);
    dut__bvm__write   = 1'b0;
    dut__dim__write   = 1'b0;
    dut__bvm__enable  = (state == LOAD_W) && tap_issue;
    dut__dim__enable  = (state == CONV) && tap_issue;
    dut__dom__enable  = (state == WRITE) && wr_now;
    dut__dom__write   = dut__dom__enable;
    dut__bvm__address = '0;
    dut__dim__address = '0;
    dut__dom__address = '0;
    dut__dom__data    = '0;
    if (dut__bvm__enable)
      dut__bvm__address = BA'(32'(kern) * KK + 32'(tap));
    if (dut__dim__enable)
      dut__dim__address = IA'((32'(row) + 32'(tr)) * IMG_DIM + 32'(col) + 32'(tc));
    if (dut__dom__enable) begin
      dut__dom__address = out_cnt;
      dut__dom__data    = wr_val;
    end
  end

  // Counters, MAC accumulator and pooling register.
  always_ff @(posedge clk) begin
    if (reset) begin
      tap     <= '0;
      tr      <= '0;
      tc      <= '0;
      row     <= '0;
      col     <= '0;
      kern    <= '0;
      out_cnt <= '0;
      acc     <= '0;
`ifdef CONV2D_MAXPOOL2_EN
      sub      <= '0;
      pool_max <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (xxx__dut__go) begin
          tap     <= '0;
          tr      <= '0;
          tc      <= '0;
          row     <= '0;
          col     <= '0;
          kern    <= '0;
          out_cnt <= '0;
`ifdef CONV2D_MAXPOOL2_EN
          sub     <= '0;
`endif
        end
        LOAD_W: tap <= tap_issue ? tap + 1'b1 : '0;
        CONV: begin
          tap <= tap_issue ? tap + 1'b1 : '0;
          if (tap_issue) begin
            if (tc == KER_LAST) begin
              tc <= '0;
              tr <= (tr == KER_LAST) ? '0 : tr + 1'b1;
            end else begin
              tc <= tc + 1'b1;
            end
          end
          // Read data lags the address by one cycle, so tap 1 carries the first product.
          if (tap == TW'(1))    acc <= ACC_W'(prod);
          else if (tap != '0)   acc <= acc + ACC_W'(prod);
        end
        WRITE: begin
          tr <= '0;
          tc <= '0;
          if (wr_now) out_cnt <= out_cnt + 1'b1;
          if (last_pix && (kern != KRN_LAST)) kern <= kern + 1'b1;
`ifdef CONV2D_MAXPOOL2_EN
          pool_max <= wr_val;
          sub      <= sub + 1'b1;
          // Walk each 2x2 block (TL, TR, BL, BR) before stepping to the next block.
          case (sub)
            2'd0: col <= col + 1'b1;
            2'd1: begin row <= row + 1'b1; col <= col - 1'b1; end
            2'd2: col <= col + 1'b1;
            default: begin
              if (last_pix) begin
                row <= '0;
                col <= '0;
              end else if (col_end) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
                row <= row - 1'b1;
              end
            end
          endcase
`else
          if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_relu_engine.sv
// Directed self-checking bench for conv2d_relu_engine (small, default and pooling configurations).
module tb_conv2d_relu_engine;
  import conv2d_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ---------------- DUT A: IMG 4, KER 3, 1 kernel, FRAC 8 ----------------
  localparam int unsigned A_BA = aw(9);
  localparam int unsigned A_IA = aw(16);
  localparam int unsigned A_OA = aw(dom_words(4, 3, 1));
`ifdef CONV2D_MAXPOOL2_EN
  localparam int unsigned A_WORDS = 1;
`else
  localparam int unsigned A_WORDS = 4;
`endif

  logic              a_go, a_fin, a_bvm_en, a_bvm_wr, a_dim_en, a_dim_wr, a_dom_en, a_dom_wr;
  logic [A_BA-1:0]   a_bvm_addr;
  logic [A_IA-1:0]   a_dim_addr;
  logic [A_OA-1:0]   a_dom_addr;
  logic [15:0]       a_bvm_q, a_dim_q, a_dom_data;
  logic [15:0]       a_img [16];
  logic [15:0]       a_w   [9];
  int unsigned       a_addr_q[$];
  logic [15:0]       a_data_q[$];

  conv2d_relu_engine #(.DATA_W(16), .FRAC_BITS(8), .IMG_DIM(4), .KER_DIM(3), .NUM_KER(1)) u_a (
    .clk(clk), .reset(reset), .xxx__dut__go(a_go), .dut__xxx__finish(a_fin),
    .dut__bvm__address(a_bvm_addr), .dut__bvm__enable(a_bvm_en), .dut__bvm__write(a_bvm_wr),
    .bvm__dut__data(a_bvm_q),
    .dut__dim__address(a_dim_addr), .dut__dim__enable(a_dim_en), .dut__dim__write(a_dim_wr),
    .dim__dut__data(a_dim_q),
    .dut__dom__address(a_dom_addr), .dut__dom__data(a_dom_data),
    .dut__dom__enable(a_dom_en), .dut__dom__write(a_dom_wr)
  );

  always @(posedge clk) begin
    if (a_bvm_en) a_bvm_q <= a_w[a_bvm_addr];
    if (a_dim_en) a_dim_q <= a_img[a_dim_addr];
  end
  always @(negedge clk) if (a_dom_en && a_dom_wr) begin
    a_addr_q.push_back(32'(a_dom_addr));
    a_data_q.push_back(a_dom_data);
  end

  // ---------------- DUT B: default parameters ----------------
  localparam int unsigned B_BA = aw(72);
  localparam int unsigned B_IA = aw(256);
  localparam int unsigned B_OA = aw(dom_words(16, 3, 8));

  logic              b_go, b_fin, b_bvm_en, b_bvm_wr, b_dim_en, b_dim_wr, b_dom_en, b_dom_wr;
  logic [B_BA-1:0]   b_bvm_addr;
  logic [B_IA-1:0]   b_dim_addr;
  logic [B_OA-1:0]   b_dom_addr;
  logic [15:0]       b_bvm_q, b_dim_q, b_dom_data;
  logic [15:0]       b_img [256];
  logic [15:0]       b_w   [72];
  logic [15:0]       b_exp [1568];
  int unsigned       b_addr_q[$];
  logic [15:0]       b_data_q[$];

  conv2d_relu_engine u_b (
    .clk(clk), .reset(reset), .xxx__dut__go(b_go), .dut__xxx__finish(b_fin),
    .dut__bvm__address(b_bvm_addr), .dut__bvm__enable(b_bvm_en), .dut__bvm__write(b_bvm_wr),
    .bvm__dut__data(b_bvm_q),
    .dut__dim__address(b_dim_addr), .dut__dim__enable(b_dim_en), .dut__dim__write(b_dim_wr),
    .dim__dut__data(b_dim_q),
    .dut__dom__address(b_dom_addr), .dut__dom__data(b_dom_data),
    .dut__dom__enable(b_dom_en), .dut__dom__write(b_dom_wr)
  );

  always @(posedge clk) begin
    if (b_bvm_en) b_bvm_q <= b_w[b_bvm_addr];
    if (b_dim_en) b_dim_q <= b_img[b_dim_addr];
  end
  always @(negedge clk) if (b_dom_en && b_dom_wr) begin
    b_addr_q.push_back(32'(b_dom_addr));
    b_data_q.push_back(b_dom_data);
  end

`ifdef CONV2D_MAXPOOL2_EN
  // ---------------- DUT C: pooling case, IMG 5, KER 2, FRAC 8 ----------------
  localparam int unsigned C_BA = aw(4);
  localparam int unsigned C_IA = aw(25);
  localparam int unsigned C_OA = aw(dom_words(5, 2, 1));

  logic              c_go, c_fin, c_bvm_en, c_bvm_wr, c_dim_en, c_dim_wr, c_dom_en, c_dom_wr;
  logic [C_BA-1:0]   c_bvm_addr;
  logic [C_IA-1:0]   c_dim_addr;
  logic [C_OA-1:0]   c_dom_addr;
  logic [15:0]       c_bvm_q, c_dim_q, c_dom_data;
  logic [15:0]       c_img [25];
  logic [15:0]       c_w   [4];
  int unsigned       c_addr_q[$];
  logic [15:0]       c_data_q[$];

  conv2d_relu_engine #(.DATA_W(16), .FRAC_BITS(8), .IMG_DIM(5), .KER_DIM(2), .NUM_KER(1)) u_c (
    .clk(clk), .reset(reset), .xxx__dut__go(c_go), .dut__xxx__finish(c_fin),
    .dut__bvm__address(c_bvm_addr), .dut__bvm__enable(c_bvm_en), .dut__bvm__write(c_bvm_wr),
    .bvm__dut__data(c_bvm_q),
    .dut__dim__address(c_dim_addr), .dut__dim__enable(c_dim_en), .dut__dim__write(c_dim_wr),
    .dim__dut__data(c_dim_q),
    .dut__dom__address(c_dom_addr), .dut__dom__data(c_dom_data),
    .dut__dom__enable(c_dom_en), .dut__dom__write(c_dom_wr)
  );

  always @(posedge clk) begin
    if (c_bvm_en) c_bvm_q <= c_w[c_bvm_addr];
    if (c_dim_en) c_dim_q <= c_img[c_dim_addr];
  end
  always @(negedge clk) if (c_dom_en && c_dom_wr) begin
    c_addr_q.push_back(32'(c_dom_addr));
    c_data_q.push_back(c_dom_data);
  end
`endif

  // ---------------- run helpers (no checking) ----------------
  // After these return, time is #1 past the edge that sampled go (edge 0).
  task automatic go_a();
    @(negedge clk); a_go = 1'b1; @(posedge clk); #1; a_go = 1'b0;
  endtask
  task automatic go_b();
    @(negedge clk); b_go = 1'b1; @(posedge clk); #1; b_go = 1'b0;
  endtask
  // Edges counted from the go edge until finish is seen high, bounded by limit.
  task automatic wait_fin_a(input int unsigned limit, output int unsigned edges);
    edges = 0;
    while (a_fin !== 1'b1 && edges < limit) begin @(posedge clk); #1; edges++; end
  endtask
  task automatic wait_fin_b(input int unsigned limit, output int unsigned edges);
    edges = 0;
    while (b_fin !== 1'b1 && edges < limit) begin @(posedge clk); #1; edges++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (a_fin !== 1'b1) begin n_fail++; $display("FAIL reset_finish: got %0b want 1", a_fin); end
    n_checks++;
    if ({a_bvm_en, a_bvm_wr, a_dim_en, a_dim_wr, a_dom_en, a_dom_wr} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %06b want 000000",
               {a_bvm_en, a_bvm_wr, a_dim_en, a_dim_wr, a_dom_en, a_dom_wr});
    end
    n_checks++;
    if ({32'(a_bvm_addr), 32'(a_dim_addr), 32'(a_dom_addr), 16'(a_dom_data)} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr_data: got bvm=%0d dim=%0d dom=%0d data=%h want all 0",
               a_bvm_addr, a_dim_addr, a_dom_addr, a_dom_data);
    end
    n_checks++;
    if ({b_fin, b_bvm_en, b_bvm_wr, b_dim_en, b_dim_wr, b_dom_en, b_dom_wr} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_default_cfg: got %07b want 1000000",
               {b_fin, b_bvm_en, b_bvm_wr, b_dim_en, b_dim_wr, b_dom_en, b_dom_wr});
    end
    @(negedge clk); reset = 1'b0;
  endtask

  // Runs DUT A once and checks every written word against one constant.
  task automatic run_a_const(input string name, input logic [15:0] want, input int unsigned nwords);
    int unsigned e;
    a_addr_q.delete(); a_data_q.delete();
    go_a();
    wait_fin_a(200, e);
    n_checks++;
    if (a_addr_q.size() != nwords) begin
      n_fail++; $display("FAIL %s_count: got %0d writes want %0d", name, a_addr_q.size(), nwords);
    end
    for (int i = 0; i < a_addr_q.size(); i++) begin
      n_checks++;
      if (a_addr_q[i] !== 32'(i) || a_data_q[i] !== want) begin
        n_fail++;
        $display("FAIL %s_word%0d: got addr %0d data %h want addr %0d data %h",
                 name, i, a_addr_q[i], a_data_q[i], i, want);
      end
    end
  endtask

  task automatic test_conv_basic();
    for (int i = 0; i < 16; i++) a_img[i] = 16'h0100;
    for (int i = 0; i < 9; i++)  a_w[i]   = 16'h0100;
    // 9 taps * (1.0 * 1.0 in Q8) = 9.0 -> 0x0900
    run_a_const("basic", 16'h0900, 4);
  endtask

  task automatic test_relu_sat();
    for (int i = 0; i < 9; i++) a_w[i] = 16'hFF00;
    run_a_const("relu", 16'h0000, 4);
    for (int i = 0; i < 16; i++) a_img[i] = 16'h7FFF;
    for (int i = 0; i < 9; i++)  a_w[i]   = 16'h7FFF;
    run_a_const("sat", 16'h7FFF, 4);
  endtask

  task automatic test_timing();
    int unsigned e;
    for (int i = 0; i < 16; i++) a_img[i] = 16'h0100;
    for (int i = 0; i < 9; i++)  a_w[i]   = 16'h0100;
    for (int run = 0; run < 2; run++) begin
      a_addr_q.delete(); a_data_q.delete();
      go_a();
      n_checks++;
      if (a_fin !== 1'b0) begin n_fail++; $display("FAIL timing_drop%0d: got %0b want 0", run, a_fin); end
      if (run == 1) begin
        // A go pulse while busy must not disturb the run.
        repeat (20) @(posedge clk);
        @(negedge clk); a_go = 1'b1; @(negedge clk); a_go = 1'b0;
        #1;
        wait_fin_a(200, e);
        e = e + 21;
      end else begin
        wait_fin_a(200, e);
      end
      // finish high in cycle 56 == 55 edges after the go edge
      n_checks++;
      if (e != 55) begin n_fail++; $display("FAIL timing_finish%0d: got edge %0d want 55", run, e); end
      n_checks++;
      if (a_data_q.size() != A_WORDS) begin
        n_fail++; $display("FAIL timing_count%0d: got %0d want %0d", run, a_data_q.size(), A_WORDS);
      end
      for (int i = 0; i < a_data_q.size(); i++) begin
        n_checks++;
        if (a_data_q[i] !== 16'h0900 || a_addr_q[i] !== 32'(i)) begin
          n_fail++;
          $display("FAIL timing_word%0d_%0d: got addr %0d data %h want addr %0d data 0900",
                   run, i, a_addr_q[i], a_data_q[i], i);
        end
      end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_b();
    for (int i = 0; i < 256; i++) b_img[i] = 16'(i * 7919 + 123);
    for (int i = 0; i < 72; i++)  b_w[i]   = 16'(i * 4099 + 12345);
  endtask

  task automatic test_full_default();
    int unsigned e;
    longint acc, r;
    fill_b();
    for (int k = 0; k < 8; k++)
      for (int row = 0; row < 14; row++)
        for (int col = 0; col < 14; col++) begin
          acc = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += longint'($signed(b_img[(row + i) * 16 + col + j])) *
                     longint'($signed(b_w[k * 9 + i * 3 + j]));
          r = acc >>> 16;
          if (r < 0) r = 0;
          if (r > 32767) r = 32767;
          b_exp[k * 196 + row * 14 + col] = 16'(r);
        end
    b_addr_q.delete(); b_data_q.delete();
    go_b();
    wait_fin_b(20000, e);
    n_checks++;
    if (e != 17329) begin n_fail++; $display("FAIL full_finish: got edge %0d want 17329", e); end
    n_checks++;
    if (b_addr_q.size() != 1568) begin
      n_fail++; $display("FAIL full_count: got %0d writes want 1568", b_addr_q.size());
    end
    for (int i = 0; i < b_addr_q.size() && i < 1568; i++) begin
      n_checks++;
      if (b_addr_q[i] !== 32'(i) || b_data_q[i] !== b_exp[i]) begin
        n_fail++;
        $display("FAIL full_word%0d: got addr %0d data %h want addr %0d data %h",
                 i, b_addr_q[i], b_data_q[i], i, b_exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int unsigned n;
    fill_b();
    go_b();
    n = 0;
    while (!(b_bvm_en === 1'b1 && b_bvm_addr === B_BA'(27)) && n < 10000) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n >= 10000) begin n_fail++; $display("FAIL midrst_k3: kernel 3 load not seen, want addr 27"); end
    repeat (30) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({b_fin, b_bvm_en, b_dim_en, b_dom_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrst_abort: got fin/bvm/dim/dom %04b want 1000", {b_fin, b_bvm_en, b_dim_en, b_dom_en});
    end
    @(negedge clk); reset = 1'b0;
    b_addr_q.delete(); b_data_q.delete();
    go_b();
    n_checks++;
    if (b_bvm_en !== 1'b1 || b_bvm_addr !== '0) begin
      n_fail++; $display("FAIL midrst_restart: got en %0b addr %0d want en 1 addr 0", b_bvm_en, b_bvm_addr);
    end
    n = 0;
    while (b_addr_q.size() == 0 && n < 2000) begin @(posedge clk); #1; n++; end
    n_checks++;
    if (b_addr_q.size() == 0) begin
      n_fail++; $display("FAIL midrst_first_write: got no write want addr 0");
    end else if (b_addr_q[0] !== 0) begin
      n_fail++; $display("FAIL midrst_first_write: got addr %0d want 0", b_addr_q[0]);
    end
`ifndef CONV2D_MAXPOOL2_EN
    n_checks++;
    if (b_data_q.size() == 0 || b_data_q[0] !== b_exp[0]) begin
      n_fail++; $display("FAIL midrst_first_data: got %h want %h",
                         (b_data_q.size() == 0) ? 16'hxxxx : b_data_q[0], b_exp[0]);
    end
`endif
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

`ifdef CONV2D_MAXPOOL2_EN
  task automatic test_maxpool();
    int unsigned e;
    logic [15:0] want [4];
    want[0] = 16'h2400; want[1] = 16'h2C00; want[2] = 16'h4C00; want[3] = 16'h5400;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) c_img[r * 5 + c] = 16'((5 * r + c) << 8);
    for (int i = 0; i < 4; i++) c_w[i] = 16'h0100;
    c_addr_q.delete(); c_data_q.delete();
    @(negedge clk); c_go = 1'b1; @(posedge clk); #1; c_go = 1'b0;
    e = 0;
    while (c_fin !== 1'b1 && e < 400) begin @(posedge clk); #1; e++; end
    // 2 + (5 + 16*6) = 103 cycles -> 102 edges after go
    n_checks++;
    if (e != 102) begin n_fail++; $display("FAIL pool_finish: got edge %0d want 102", e); end
    n_checks++;
    if (c_addr_q.size() != 4 || c_bvm_wr !== 1'b0 || c_dim_wr !== 1'b0) begin
      n_fail++; $display("FAIL pool_count: got %0d writes want 4", c_addr_q.size());
    end
    for (int i = 0; i < c_addr_q.size() && i < 4; i++) begin
      n_checks++;
      if (c_addr_q[i] !== 32'(i) || c_data_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL pool_word%0d: got addr %0d data %h want addr %0d data %h",
                 i, c_addr_q[i], c_data_q[i], i, want[i]);
      end
    end
  endtask
`endif

  initial begin
    a_go = 1'b0;
    b_go = 1'b0;
`ifdef CONV2D_MAXPOOL2_EN
    c_go = 1'b0;
`endif
    test_reset();
`ifndef CONV2D_MAXPOOL2_EN
    test_conv_basic();
    test_relu_sat();
`endif
    test_timing();
`ifndef CONV2D_MAXPOOL2_EN
    test_full_default();
`endif
    test_reset_mid_run();
`ifdef CONV2D_MAXPOOL2_EN
    test_maxpool();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
